coin_change_return: RTL and testbench
=====================================

// Module: coin_change_return
// PURPOSE
//   Downstream stage of the coin-summing block. Takes one credit total per transaction.
//   - Issues a one-cycle vend enable when credit >= PRICE.
//   - Returns excess credit (or all of it when credit < PRICE) as coins, largest-first, via handshake pulses.
//   - Sits between the coin adder and the coin-return solenoid/motor driver.
// PARAMETERS
//   PRICE        51    item price in cents
//   CREDIT_W     8     width of credit/remaining-change datapath (max 255 cents)
//   ACK_TIMEOUT  1023  cycles to wait for disp_ack (used only when COIN_ACK_TIMEOUT_EN is defined)
// PORTS
//   clk          in   1         single clock, all logic on posedge
//   rst_n        in   1         asynchronous active-low reset
//   req_valid    in   1         credit total presented
//   req_ready    out  1         block idle, can accept a request
//   req_credit   in   CREDIT_W  total credit in cents, sampled on req_valid & req_ready
//   vend_en      out  1         one-cycle pulse: motor enable (credit >= PRICE)
//   disp_25      out  1         dispense quarter, held until acked
//   disp_10      out  1         dispense dime, held until acked
//   disp_5       out  1         dispense nickel, held until acked
//   disp_1       out  1         dispense penny, held until acked
//   disp_ack     in   1         dispenser done with current coin (1-cycle pulse)
//   busy         out  1         transaction in progress (= ~req_ready)
//   done         out  1         one-cycle pulse, transaction complete
//   err          out  1         one-cycle pulse, dispense timeout (macro only; else tied 0)
// BEHAVIOUR
//   - Reset: all outputs 0 except req_ready=1; FSM=IDLE; remaining=0. Reset mid-transaction aborts it
//     immediately; the pending coin is dropped and no done pulse follows.
//   - FSM states and transitions:
//     - IDLE: req_ready=1. On req_valid, capture req_credit -> CALC at T+1.
//     - CALC: compute remaining.
//       - credit >= PRICE: remaining = credit - PRICE; vend_en=1 this cycle.
//       - credit < PRICE: remaining = credit (full refund); no vend_en.
//       -> ISSUE.
//     - ISSUE:
//       - remaining == 0: -> DONE.
//       - Otherwise select the largest coin <= remaining from {25,10,5,1} and register exactly one disp_x high.
//       -> WAIT_ACK.
//     - WAIT_ACK: hold disp_x.
//       - On disp_ack: disp_x low next cycle, remaining -= coin value, -> ISSUE.
//     - DONE: done=1 for one cycle -> IDLE.
//   - disp_ack outside WAIT_ACK is ignored.
//   - req_valid while busy is not accepted; the upstream holds it until req_ready is high.
//   - Exactly one disp_x is high at any time. Subtraction never underflows by construction.
//   - Credit == PRICE: vend_en pulse, zero coins, done 2 cycles after CALC.
//   - Credit == 0: no vend, no coins, done.
// CONFIGURATION
//   COIN_ACK_TIMEOUT_EN
//     - Defined: a counter runs in WAIT_ACK. Reaching ACK_TIMEOUT with no disp_ack drops disp_x,
//       pulses err for 1 cycle, and goes -> IDLE with no done pulse.
//     - Undefined: WAIT_ACK waits forever; err is tied 0 and no counter is built.
// STRUCTURE
//   - Shared header coin_pkg.vh: coin value constants (25/10/5/1), FSM state encodings, default PRICE.
//   - Sub-module coin_greedy_select: combinational. Input remaining; outputs one-hot coin select and coin value.
//   - Top holds the FSM, remaining register, output registers and optional timeout counter.
// TESTING
//   1. credit=51 -> vend_en pulse at CALC; no disp_x; done pulse; req_ready back high.
//   2. credit=93 -> vend_en; coins 25,10,5,1,1 in order, each held until ack; done after 5th ack.
//   3. credit=30 -> no vend_en; refund 25 then 5; done.
//   4. credit=93, rst_n low during 2nd WAIT_ACK -> all disp_x=0 at once; no done; next request works.
//   5. req_valid with credit=60 while busy -> not captured until done; second transaction returns 5 + 1+1+1+1.
//   6. COIN_ACK_TIMEOUT_EN, ACK_TIMEOUT=16, credit=76, disp_ack withheld
//      -> disp_25 drops after 16 cycles; err pulse; no done; req_ready=1.

Source files
------------

// File: rtl/coin_change_return_pkg.sv
// Shared definitions for the coin change/return stage: coin values, one-hot
// dispense bit positions, FSM state encoding and the default item price.
package coin_change_return_pkg;

    localparam int COIN_25 = 25;
    localparam int COIN_10 = 10;
    localparam int COIN_5  = 5;
    localparam int COIN_1  = 1;

    localparam int DEFAULT_PRICE = 51;

    // Bit positions of each coin inside the one-hot dispense vector
    localparam int COIN_N = 4;
    localparam int IDX_25 = 3;
    localparam int IDX_10 = 2;
    localparam int IDX_5  = 1;
    localparam int IDX_1  = 0;

    typedef logic [COIN_N-1:0] coin_sel_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CALC     = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/coin_change_return_greedy_select.sv
// Greedy coin picker: returns the largest coin not exceeding the remaining change
// as a one-hot select plus its value. Zero remaining selects nothing.
module coin_change_return_greedy_select
    import coin_change_return_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] remaining,
    output coin_sel_t           coin_sel,
    output logic [CREDIT_W-1:0] coin_val
);

    always_comb begin
        coin_sel = '0;
        coin_val = '0;
        if (remaining >= CREDIT_W'(COIN_25)) begin
            coin_sel[IDX_25] = 1'b1;
            coin_val         = CREDIT_W'(COIN_25);
        end else if (remaining >= CREDIT_W'(COIN_10)) begin
            coin_sel[IDX_10] = 1'b1;
            coin_val         = CREDIT_W'(COIN_10);
        end else if (remaining >= CREDIT_W'(COIN_5)) begin
            coin_sel[IDX_5] = 1'b1;
            coin_val        = CREDIT_W'(COIN_5);
        end else if (remaining != '0) begin
            coin_sel[IDX_1] = 1'b1;
            coin_val        = CREDIT_W'(COIN_1);
        end
    end

endmodule

// File: rtl/coin_change_return.sv
// Coin change/return stage: vends when credit covers PRICE and returns the rest
// largest-coin-first over a hold-until-ack dispense handshake.
// Optional COIN_ACK_TIMEOUT_EN adds an ack timeout that aborts with an err pulse.
module coin_change_return
    import coin_change_return_pkg::*;
#(
    parameter int PRICE    = DEFAULT_PRICE,
    parameter int CREDIT_W = 8
`ifdef COIN_ACK_TIMEOUT_EN
    ,
    parameter int ACK_TIMEOUT = 1023
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CREDIT_W-1:0] req_credit,
    output logic                vend_en,
    output logic                disp_25,
    output logic                disp_10,
    output logic                disp_5,
    output logic                disp_1,
    input  logic                disp_ack,
    output logic                busy,
    output logic                done,
    output logic                err
);

    // Handshakes: a request transfers on a clock edge where req_valid and
    // req_ready are both high; a coin is offered by holding its disp_x high
    // and completes on the edge where disp_ack is sampled high in WAIT_ACK.

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] remaining_q, remaining_d;
    coin_sel_t           disp_q, disp_d;

    coin_sel_t           sel;
    logic [CREDIT_W-1:0] sel_val;
    logic                credit_ok;

    coin_change_return_greedy_select #(
        .CREDIT_W (CREDIT_W)
    ) u_select (
        .remaining (remaining_q),
        .coin_sel  (sel),
        .coin_val  (sel_val)
    );

    // remaining_q holds the raw credit while in CALC
    assign credit_ok = (remaining_q >= CREDIT_W'(PRICE));

`ifdef COIN_ACK_TIMEOUT_EN
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        disp_d      = disp_q;
`ifdef COIN_ACK_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    remaining_d = req_credit;
                    state_d     = ST_CALC;
                end
            end
            ST_CALC: begin
                if (credit_ok) begin
                    remaining_d = remaining_q - CREDIT_W'(PRICE);
                end
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (remaining_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    disp_d  = sel;
                    state_d = ST_WAIT_ACK;
`ifdef COIN_ACK_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_WAIT_ACK: begin
                // remaining_q is stable here, so sel_val still names the coin on offer
                if (disp_ack) begin
                    disp_d      = '0;
                    remaining_d = remaining_q - sel_val;
                    state_d     = ST_ISSUE;
                end
`ifdef COIN_ACK_TIMEOUT_EN
                else if (cnt_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    disp_d      = '0;
                    remaining_d = '0;
                    err_d       = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            disp_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            disp_q      <= disp_d;
        end
    end

`ifdef COIN_ACK_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = ~req_ready;
    assign vend_en   = (state_q == ST_CALC) && credit_ok;
    assign done      = (state_q == ST_DONE);

    assign disp_25 = disp_q[IDX_25];
    assign disp_10 = disp_q[IDX_10];
    assign disp_5  = disp_q[IDX_5];
    assign disp_1  = disp_q[IDX_1];

endmodule

// File: tb/tb_coin_change_return.sv
// Directed bench for coin_change_return: a reference change model fills an
// expected-coin queue at request time; dispensed coins are popped and compared.
module tb_coin_change_return;

    localparam int CREDIT_W = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid = 1'b0;
    logic [CREDIT_W-1:0] req_credit = '0;
    logic                disp_ack = 1'b0;
    logic                req_ready, vend_en, busy, done, err;
    logic                disp_25, disp_10, disp_5, disp_1;
    logic [3:0]          disp;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    int vend_cnt = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    logic [CREDIT_W-1:0] exp_q[$];

    assign disp = {disp_25, disp_10, disp_5, disp_1};

    coin_change_return #(
        .PRICE    (51),
        .CREDIT_W (CREDIT_W)
`ifdef COIN_ACK_TIMEOUT_EN
        ,
        .ACK_TIMEOUT (16)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_credit (req_credit),
        .vend_en    (vend_en),
        .disp_25    (disp_25),
        .disp_10    (disp_10),
        .disp_5     (disp_5),
        .disp_1     (disp_1),
        .disp_ack   (disp_ack),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vend_en === 1'b1) vend_cnt++;
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int coin_val(input logic [3:0] d);
        case (d)
            4'b1000: return 25;
            4'b0100: return 10;
            4'b0010: return 5;
            4'b0001: return 1;
            default: return 0;
        endcase
    endfunction

    // Reference model: vend decision and greedy change list
    task automatic push_expected(input int credit, output logic exp_vend);
        int rem;
        exp_vend = (credit >= 51);
        rem = exp_vend ? credit - 51 : credit;
        while (rem >= 25) begin exp_q.push_back(8'd25); rem -= 25; end
        while (rem >= 10) begin exp_q.push_back(8'd10); rem -= 10; end
        while (rem >= 5)  begin exp_q.push_back(8'd5);  rem -= 5;  end
        while (rem >= 1)  begin exp_q.push_back(8'd1);  rem -= 1;  end
    endtask

    // Returns at the negedge following the capture edge (DUT in CALC)
    task automatic send(input int credit);
        logic exp_vend;
        int   t;
        push_expected(credit, exp_vend);
        req_credit = CREDIT_W'(credit);
        req_valid  = 1'b1;
        t = 0;
        while (req_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", (t < 200), 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("vend_en", vend_en, exp_vend);
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_coin();
        logic [CREDIT_W-1:0] e;
        int t;
        t = 0;
        while (disp == 4'b0000 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("coin_wait", (disp != 4'b0000), 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("coin_value", coin_val(disp), e);
        check("one_hot", $countones(disp), 1);
    endtask

    task automatic ack_coin();
        int hold, v;
        v = coin_val(disp);
        hold = $urandom_range(0, 3);
        repeat (hold) @(negedge clk);
        check("coin_held", coin_val(disp), v);
        disp_ack = 1'b1;
        @(negedge clk);
        disp_ack = 1'b0;
        check("disp_drop", disp, 0);
    endtask

    // Serves coins until done; cycles = negedges from CALC to the done pulse
    task automatic serve(output int cycles);
        int t;
        t = 0;
        cycles = -1;
        while (t < 400) begin
            @(negedge clk);
            t++;
            if (done === 1'b1) begin
                cycles = t;
                break;
            end
            if (disp != 4'b0000) begin
                wait_coin();
                check("ready_low_while_busy", req_ready, 0);
                ack_coin();
                t++;
            end
        end
        check("done_seen", (cycles >= 0), 1);
        check("scoreboard_empty", exp_q.size(), 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("ready_after_done", req_ready, 1);
    endtask

    initial begin
        int cyc;
        int done_before;

        // Reset state
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_vend", vend_en, 0);
        check("rst_disp", disp, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray ack while idle is ignored
        disp_ack = 1'b1;
        @(negedge clk);
        disp_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_ready", req_ready, 1);
        check("stray_ack_disp", disp, 0);

        // Exact price: vend, no coins, done two cycles after CALC
        send(51);
        serve(cyc);
        check("exact_done_latency", cyc, 2);

        // 93 -> 25,10,5,1,1
        send(93);
        serve(cyc);

        // Under price: full refund 25,5
        send(30);
        serve(cyc);

        // Reset during the second coin's WAIT_ACK
        send(93);
        wait_coin();
        ack_coin();
        @(negedge clk);
        wait_coin();
        done_before = done_cnt;
        rst_n = 1'b0;
        #1;
        check("abort_disp", disp, 0);
        check("abort_ready", req_ready, 1);
        check("abort_done", done, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt, done_before);

        send(30);
        serve(cyc);

        // Zero credit
        send(0);
        serve(cyc);
        check("zero_done_latency", cyc, 2);

        // Request held while busy is taken only after done
        send(76);
        req_credit = 8'd60;
        req_valid  = 1'b1;
        serve(cyc);
        send(60);
        serve(cyc);

`ifdef COIN_ACK_TIMEOUT_EN
        begin
            int n;
            send(76);
            done_before = done_cnt;
            wait_coin();
            n = 1;
            while (disp != 4'b0000 && n < 40) begin
                @(negedge clk);
                if (disp != 4'b0000) n++;
            end
            check("tmo_hold_cycles", n, 16);
            check("tmo_err", err, 1);
            check("tmo_ready", req_ready, 1);
            @(negedge clk);
            check("tmo_err_pulse", err, 0);
            check("tmo_no_done", done_cnt, done_before);
        end
        check("total_vend", vend_cnt, 6);
        check("total_err", err_cnt, 1);
`else
        check("total_vend", vend_cnt, 5);
        check("total_err", err_cnt, 0);
`endif
        check("total_done", done_cnt, 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
